wchb_arbiter_ctrl: RTL and testbench

//  Clocked round-robin arbiter sharing one asynchronous WCHB input channel (4-phase RTZ, bundled data)

---
 rtl/wchb_arb_pkg.sv | 18 +
 rtl/wchb_arbiter_ctrl_sync_ff.sv | 30 +++
 rtl/wchb_arbiter_ctrl.sv | 148 ++++++++++++++
 tb/tb_wchb_arbiter_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wchb_arb_pkg.sv
// Shared definitions for the WCHB round-robin arbiter controller.
//   state_t : handshake FSM states (IDLE, SETUP, REQ_HI, REQ_LO)
//   DEF_*   : default parameter values used by wchb_arbiter_ctrl
package wchb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    REQ_HI = 2'd2,
    REQ_LO = 2'd3
  } state_t;

  localparam int DEF_N_REQ          = 4;
  localparam int DEF_WIDTH          = 32;
  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/wchb_arbiter_ctrl_sync_ff.sv
// sync_ff: multi-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk   in  clock
//   rst_n in  asynchronous active-low reset, chain clears to 0
//   d     in  asynchronous input
//   q     out synchronized output, STAGES cycles behind d
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // NOTE: a flop chain uses non-blocking assignments so every stage samples
  // its predecessor's pre-edge value; blocking would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/wchb_arbiter_ctrl.sv
// wchb_arbiter_ctrl: round-robin arbiter that shares one 4-phase
// (return-to-zero, bundled-data) WCHB input channel among N_REQ
// synchronous requesters.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   i_valid     per-requester request, held until its o_ready pulse
//   i_data      per-requester payload, requester k at [k*WIDTH +: WIDTH]
//   o_ready     one-cycle pulse when requester k's transfer completes
//   o_grant     one-hot current owner, 0 when idle
//   o_busy      handshake in progress
//   o_req       registered 4-phase request into the channel
//   i_ack       asynchronous 4-phase acknowledge from the channel
//   o_data      bundled data, held from SETUP until the next grant
//   o_timeout   sticky watchdog flag
// Build option: define WCHB_ARB_TIMEOUT_EN to enable the watchdog counter;
// otherwise o_timeout is tied to 0.
module wchb_arbiter_ctrl
  import wchb_arb_pkg::*;
#(
  parameter int N_REQ          = DEF_N_REQ,
  parameter int WIDTH          = DEF_WIDTH,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       i_valid,
  input  logic [N_REQ*WIDTH-1:0] i_data,
  output logic [N_REQ-1:0]       o_ready,
  output logic [N_REQ-1:0]       o_grant,
  output logic                   o_busy,
  output logic                   o_req,
  input  logic                   i_ack,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_timeout
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_REQ - 1);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] pick;
  logic             ack_s;

  // First valid requester at or after 'start', wrapping around.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                               input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] sel;
    logic             found;
    int               idx;
    sel   = start;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(start) + i) % N_REQ;
      if (!found && valid[idx]) begin
        sel   = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign pick   = rr_pick(i_valid, ptr);
  assign o_busy = (state != IDLE);

  sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (i_ack),
    .q     (ack_s)
  );

  // Async reset clears o_req at once, even mid-handshake. A grant is only
  // issued once the channel has returned to zero (ack_s low), so a reset that
  // interrupts a handshake never starts a new one on a stale acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      o_req   <= 1'b0;
      o_grant <= '0;
      o_ready <= '0;
      o_data  <= '0;
    end else begin
      o_ready <= '0;
      unique case (state)
        IDLE: begin
          if (|i_valid && !ack_s) begin
            state   <= SETUP;
            o_data  <= i_data[int'(pick)*WIDTH +: WIDTH];
            o_grant <= N_REQ'(1) << pick;
            ptr     <= (pick == LAST) ? '0 : pick + IDX_W'(1);
          end
        end
        // One full cycle of data setup before the request edge.
        SETUP: begin
          state <= REQ_HI;
          o_req <= 1'b1;
        end
        REQ_HI: begin
          if (ack_s) begin
            state <= REQ_LO;
            o_req <= 1'b0;
          end
        end
        REQ_LO: begin
          if (!ack_s) begin
            state   <= IDLE;
            o_ready <= o_grant;
            o_grant <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WCHB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tcnt;
  logic             entering;
  logic             waiting;

  // Counter restarts on entry to each wait phase and counts cycles spent
  // waiting for the acknowledge to toggle; it saturates, the flag is sticky.
  assign entering = (state == SETUP) || (state == REQ_HI && ack_s);
  assign waiting  = (state == REQ_HI && !ack_s) || (state == REQ_LO && ack_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt      <= '0;
      o_timeout <= 1'b0;
    end else if (entering) begin
      tcnt <= '0;
    end else if (waiting) begin
      if (tcnt != CNT_LAST) tcnt <= tcnt + CNT_W'(1);
      if (tcnt == CNT_LAST) o_timeout <= 1'b1;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_wchb_arbiter_ctrl.sv
// Self-checking bench for wchb_arbiter_ctrl: directed phases (reset, rotation,
// latency, data hold, reset mid-handshake, stalled acknowledge) plus a
// randomized phase checked against a round-robin reference model.
module tb_wchb_arbiter_ctrl;

  localparam int N    = 4;
  localparam int W    = 32;
  localparam int SYNC = 2;
  localparam int TO   = 16;
`ifdef WCHB_ARB_TIMEOUT_EN
  localparam logic EXP_TO = 1'b1;
`else
  localparam logic EXP_TO = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   i_valid;
  logic [N*W-1:0] i_data;
  logic [N-1:0]   o_ready;
  logic [N-1:0]   o_grant;
  logic           o_busy;
  logic           o_req;
  logic           i_ack;
  logic [W-1:0]   o_data;
  logic           o_timeout;

  wchb_arbiter_ctrl #(
    .N_REQ(N), .WIDTH(W), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .o_ready   (o_ready),
    .o_grant   (o_grant),
    .o_busy    (o_busy),
    .o_req     (o_req),
    .i_ack     (i_ack),
    .o_data    (o_data),
    .o_timeout (o_timeout)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  logic         ack_auto;
  logic         ack_d1;
  logic [W-1:0] req_data [N];
  int           ptr_m;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1ns after the edge. The channel model
  // echoes o_req back as i_ack with a short delay when ack_auto is set.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ack_auto) begin
      i_ack  = ack_d1;
      ack_d1 = o_req;
    end
  endtask

  task automatic set_data(input int k, input logic [W-1:0] v);
    i_data[k*W +: W] = v;
    req_data[k]      = v;
  endtask

  // Round-robin rule: the pending requester at the smallest forward distance
  // from the pointer wins.
  function automatic int rr_expect(input logic [N-1:0] pend, input int p);
    int best;
    int bd;
    best = -1;
    bd   = N;
    for (int k = 0; k < N; k++) begin
      if (pend[k] && ((k - p + N) % N) < bd) begin
        bd   = (k - p + N) % N;
        best = k;
      end
    end
    return best;
  endfunction

  task automatic add_arrivals();
    logic [N-1:0] m;
    m = N'($urandom_range(1, (1 << N) - 1));
    for (int k = 0; k < N; k++) begin
      if (m[k] && !i_valid[k]) begin
        set_data(k, $urandom);
        i_valid[k] = 1'b1;
      end
    end
  endtask

  // Follows one transfer for requester w from grant to its o_ready pulse.
  task automatic xfer(input int w, input bit drop, input bit scramble);
    int           n;
    logic [W-1:0] exp_d;
    logic         data_ok;
    n = 0;
    while (o_grant == '0 && n < 64) begin
      tick();
      n++;
    end
    check("grant_seen", W'(o_grant != '0), 1);
    check("grant", W'(o_grant), W'(1 << w));
    exp_d = req_data[w];
    check("data_at_grant", o_data, exp_d);
    check("busy_in_xfer", W'(o_busy), 1);
    if (scramble) i_data[w*W +: W] = $urandom;
    data_ok = 1'b1;
    n = 0;
    while (o_ready == '0 && n < 200) begin
      tick();
      n++;
      if (o_data !== exp_d) data_ok = 1'b0;
    end
    check("ready_seen", W'(o_ready != '0), 1);
    check("ready", W'(o_ready), W'(1 << w));
    check("grant_clear_at_ready", W'(o_grant), 0);
    check("data_stable", W'(data_ok), 1);
    if (drop) i_valid[w] = 1'b0;
  endtask

  initial begin
    int n;
    int w;
    rst_n    = 1'b0;
    i_valid  = '0;
    i_ack    = 1'b0;
    ack_auto = 1'b1;
    ack_d1   = 1'b0;
    for (int k = 0; k < N; k++) set_data(k, $urandom);
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_req",     W'(o_req), 0);
    check("rst_grant",   W'(o_grant), 0);
    check("rst_ready",   W'(o_ready), 0);
    check("rst_busy",    W'(o_busy), 0);
    check("rst_data",    o_data, 0);
    check("rst_timeout", W'(o_timeout), 0);
    rst_n = 1'b1;
    ptr_m = 0;

    // All requesters held valid: strict rotation from reset
    i_valid = '1;
    for (int t = 0; t < 2 * N; t++) begin
      xfer(t % N, 1'b0, 1'b0);
      if (t == 2 * N - 1) i_valid = '0;
      tick();
      check("ready_one_cycle", W'(o_ready), 0);
    end

    // Directed latency and data hold
    set_data(0, 32'hDEAD_BEEF);
    i_valid = 4'b0001;
    tick();
    check("setup_busy",  W'(o_busy), 1);
    check("setup_noreq", W'(o_req), 0);
    check("setup_grant", W'(o_grant), 1);
    check("setup_data",  o_data, 32'hDEAD_BEEF);
    tick();
    check("req_rise", W'(o_req), 1);
    i_data[0 +: W] = 32'h1;
    xfer(0, 1'b1, 1'b0);
    tick();
    check("ready_one_cycle", W'(o_ready), 0);
    check("data_held_idle", o_data, 32'hDEAD_BEEF);
    ptr_m = 1;

    // Randomized traffic against the round-robin model
    for (int t = 0; t < 40; t++) begin
      if (i_valid == '0) add_arrivals();
      w = rr_expect(i_valid, ptr_m);
      xfer(w, 1'b1, 1'b1);
      ptr_m = (w + 1) % N;
      if ($urandom_range(0, 1) == 1) add_arrivals();
      tick();
      check("ready_one_cycle", W'(o_ready), 0);
    end
    // Drain anything still pending
    n = 0;
    while (i_valid != '0 && n < 8) begin
      w = rr_expect(i_valid, ptr_m);
      xfer(w, 1'b1, 1'b0);
      ptr_m = (w + 1) % N;
      tick();
      n++;
    end

    // Reset in REQ_HI with acknowledge high
    ack_auto = 1'b0;
    i_ack    = 1'b0;
    set_data(0, $urandom);
    i_valid = 4'b0001;
    n = 0;
    while (!o_req && n < 20) begin
      tick();
      n++;
    end
    check("pre_reset_req", W'(o_req), 1);
    i_ack = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_req",   W'(o_req), 0);
    check("async_reset_grant", W'(o_grant), 0);
    check("async_reset_busy",  W'(o_busy), 0);
    i_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (SYNC + 1) tick();
    set_data(1, $urandom);
    i_valid = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("no_grant_ack_high", W'(o_grant), 0);
    end
    i_ack = 1'b0;
    repeat (SYNC) tick();
    check("no_grant_during_sync", W'(o_grant), 0);
    tick();
    check("grant_after_ack_low", W'(o_grant), 4'b0010);
    ack_auto = 1'b1;
    ack_d1   = o_req;
    xfer(1, 1'b1, 1'b0);
    tick();
    check("ready_one_cycle", W'(o_ready), 0);

    // Stalled acknowledge: watchdog behaviour
    ack_auto = 1'b0;
    i_ack    = 1'b0;
    set_data(2, $urandom);
    i_valid = 4'b0100;
    n = 0;
    while (!o_req && n < 20) begin
      tick();
      n++;
    end
    check("stall_req", W'(o_req), 1);
    repeat (TO - 1) tick();
    check("timeout_before_limit", W'(o_timeout), 0);
    tick();
    check("timeout_at_limit", W'(o_timeout), W'(EXP_TO));
    repeat (10) tick();
    check("stall_still_waiting", W'(o_req), 1);
    ack_auto = 1'b1;
    ack_d1   = o_req;
    xfer(2, 1'b1, 1'b0);
    tick();
    check("timeout_sticky", W'(o_timeout), W'(EXP_TO));
    check("idle_after_stall", W'(o_busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
